// File: rtl/frame_streamer.sv
// Raster pixel source: walks a WIDTH x HEIGHT frame out of a synchronous-read
// memory and emits it as a valid/ready pixel stream with hsync/vsync tags.
module frame_streamer #(
   parameter int PIXEL_SIZE = 24,
   parameter int WIDTH      = 640,
   parameter int HEIGHT     = 480,
   parameter int ADDR_W     = 19,
   parameter int H_BLANK    = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  rd_en,
   output logic [ADDR_W-1:0]     rd_addr,
   input  logic [PIXEL_SIZE-1:0] rd_data,
   input  logic                  ready,
   output logic                  en,
   output logic [PIXEL_SIZE-1:0] data,
   output logic                  hsync,
   output logic                  vsync,
   output logic                  busy,
   output logic                  done
);
   localparam int CW = (WIDTH > 1)   ? $clog2(WIDTH)   : 1;
   localparam int RW = (HEIGHT > 1)  ? $clog2(HEIGHT)  : 1;
   localparam int BW = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;

   typedef enum logic [2:0] {IDLE, FETCH, BLANK, DRAIN, DONE} state_t;
   state_t state, state_nx;

   logic [CW-1:0]         col;
   logic [RW-1:0]         row;
   logic [BW-1:0]         blank_cnt;
   logic [ADDR_W-1:0]     addr;
   logic                  infl_v, infl_h, infl_f;
   logic                  out_v, out_h, out_f;
   logic [PIXEL_SIZE-1:0] out_d;
   logic                  skid_v, skid_h, skid_f;
   logic [PIXEL_SIZE-1:0] skid_d;
   logic                  hs, out_free, col_last, row_last;
   logic [1:0]            occ;

   assign hs       = out_v & ready;
   assign out_free = ~out_v | hs;
   assign col_last = (col == CW'(WIDTH - 1));
   assign row_last = (row == RW'(HEIGHT - 1));
   // Pixels held or owed after this cycle's handshake; a new read needs a free slot.
   assign occ      = 2'(out_v) + 2'(skid_v) + 2'(infl_v) - 2'(hs);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      rd_en    = 1'b0;
      case (state)
         IDLE:  if (start) state_nx = FETCH;
         FETCH: if (occ < 2'd2) begin
            rd_en = 1'b1;
            if (col_last && row_last)        state_nx = DRAIN;
            else if (col_last && H_BLANK > 0) state_nx = BLANK;
         end
         BLANK: if (blank_cnt == BW'(H_BLANK - 1)) state_nx = FETCH;
         DRAIN: if (hs && !skid_v && !infl_v) state_nx = DONE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col       <= '0;
         row       <= '0;
         addr      <= '0;
         blank_cnt <= '0;
         infl_v    <= 1'b0;
         infl_h    <= 1'b0;
         infl_f    <= 1'b0;
      end else begin
         if (rd_en) begin
            if (col_last) begin
               col <= '0;
               row <= row_last ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
            addr <= (col_last && row_last) ? '0 : addr + 1'b1;
         end
         blank_cnt <= (state == BLANK) ? blank_cnt + 1'b1 : '0;
         // Sync tags follow the read so they stay attached to the pixel.
         infl_v <= rd_en;
         infl_h <= (col == '0);
         infl_f <= (col == '0) && (row == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_v  <= 1'b0;
         out_h  <= 1'b0;
         out_f  <= 1'b0;
         out_d  <= '0;
         skid_v <= 1'b0;
         skid_h <= 1'b0;
         skid_f <= 1'b0;
         skid_d <= '0;
      end else begin
         if (out_free) begin
            if (skid_v) begin
               out_v <= 1'b1;
               out_d <= skid_d;
               out_h <= skid_h;
               out_f <= skid_f;
            end else if (infl_v) begin
               out_v <= 1'b1;
               out_d <= rd_data;
               out_h <= infl_h;
               out_f <= infl_f;
            end else begin
               out_v <= 1'b0;
            end
         end
         if ((skid_v && out_free) || (!skid_v && !out_free && infl_v)) begin
            skid_v <= infl_v;
            skid_d <= rd_data;
            skid_h <= infl_h;
            skid_f <= infl_f;
         end
      end
   end

   assign rd_addr = addr;
   assign en      = out_v;
   assign data    = out_d;
   assign hsync   = out_h;
   assign vsync   = out_f;
   assign busy    = (state != IDLE);
   assign done    = (state == DONE);
endmodule
